data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory/I/O block between two requesters: port 0 is the CPU load/store path, port 1 is the program loader/debug DMA. Per cycle it grants at most one port, muxes that port's address, write data and write enable onto the memory, and returns read data to the granted port. It uses round-robin fairness plus an optional bounded burst lock. It sits between the core datapath and `data_memory_and_io`; a requester that is not granted must stall.

---
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 tb/tb_data_mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared data memory / I/O block: CPU on port 0, loader/DMA on port 1.
// The grant is combinational. Round-robin fairness, with an optional lock that holds at most MAX_BURST grants.
module data_mem_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          Lock0,
    input  logic          Lock1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    input  logic          WE0,
    input  logic          WE1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic [DW-1:0] RData0,
    output logic [DW-1:0] RData1,
    output logic [AW-1:0] MemA,
    output logic [DW-1:0] MemWD,
    output logic          MemWE,
    input  logic [DW-1:0] MemRD,
    output logic [1:0]    Owner
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [CW-1:0] burst_cnt, burst_d;
    logic          last_gnt, last_d;
    logic          gnt0, gnt1;
    logic          burst_ok;

    assign burst_ok = (burst_cnt < MAX_CNT);

    // Handshake: a requester holds Req and its access fields stable until it sees Gnt=1.
    // The access completes on the edge that ends the Gnt cycle. Req must not depend on Gnt.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset) begin
            if (owner_q == OWN_P0 && Req0 && burst_ok) begin
                gnt0 = 1'b1;
            end else if (owner_q == OWN_P1 && Req1 && burst_ok) begin
                gnt1 = 1'b1;
            end else if (Req0 && Req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = Req0;
                gnt1 = Req1;
            end
        end
    end

    // When no port is granted, or the non-owner is granted, the lock falls back to none.
    always_comb begin
        owner_d = OWN_NONE;
        burst_d = '0;
        last_d  = last_gnt;
        if (gnt0) begin
            last_d = 1'b0;
            if (Lock0 && owner_q == OWN_P0 && burst_ok) begin
                owner_d = OWN_P0;
                burst_d = burst_cnt + CW'(1);
            end else if (Lock0) begin
                owner_d = OWN_P0;
                burst_d = CW'(1);
            end
        end else if (gnt1) begin
            last_d = 1'b1;
            if (Lock1 && owner_q == OWN_P1 && burst_ok) begin
                owner_d = OWN_P1;
                burst_d = burst_cnt + CW'(1);
            end else if (Lock1) begin
                owner_d = OWN_P1;
                burst_d = CW'(1);
            end
        end
    end

    // last_gnt resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            owner_q   <= OWN_NONE;
            burst_cnt <= '0;
            last_gnt  <= 1'b1;
        end else begin
            owner_q   <= owner_d;
            burst_cnt <= burst_d;
            last_gnt  <= last_d;
        end
    end

    assign Gnt0   = gnt0;
    assign Gnt1   = gnt1;
    assign MemA   = gnt0 ? Addr0  : (gnt1 ? Addr1  : '0);
    assign MemWD  = gnt0 ? WData0 : (gnt1 ? WData1 : '0);
    assign MemWE  = gnt0 ? WE0    : (gnt1 ? WE1    : 1'b0);
    assign RData0 = gnt0 ? MemRD : '0;
    assign RData1 = gnt1 ? MemRD : '0;
    assign Owner  = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed, table-driven bench for data_mem_arbiter with MAX_BURST = 4.
// Each vector is one clock cycle. Outputs are compared mid-cycle, and the lock state is compared just after the edge.
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;

  logic          CLK = 1'b0;
  logic          Reset, Req0, Req1, Lock0, Lock1, WE0, WE1;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] WData0, WData1, MemRD;
  logic          Gnt0, Gnt1, MemWE;
  logic [DW-1:0] RData0, RData1, MemWD;
  logic [AW-1:0] MemA;
  logic [1:0]    Owner;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .WE0(WE0), .WE1(WE1), .Gnt0(Gnt0), .Gnt1(Gnt1),
    .RData0(RData0), .RData1(RData1), .MemA(MemA), .MemWD(MemWD),
    .MemWE(MemWE), .MemRD(MemRD), .Owner(Owner)
  );

  typedef struct {
    string       name;
    logic        rst, r0, r1, l0, l1, we0, we1;
    logic [31:0] a0, d0, a1, d1, rd;
    logic        g0, g1, mwe;
    logic [31:0] ma, mwd, rd0, rd1;
    logic [1:0]  own;
    logic [2:0]  cnt;
  } vec_t;

  // Grants and lock state are hand-computed. The memory-side values are then taken from the granted port.
  function automatic vec_t v(input string name, input logic rst, r0, r1, l0, l1, we0, we1,
                             input logic [31:0] a0, d0, a1, d1, rd,
                             input logic g0, g1, input logic [1:0] own, input logic [2:0] cnt);
    vec_t t;
    t.name = name; t.rst = rst; t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1;
    t.we0 = we0; t.we1 = we1; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.rd = rd;
    t.g0 = g0; t.g1 = g1; t.own = own; t.cnt = cnt;
    t.ma  = g0 ? a0  : (g1 ? a1  : 32'h0);
    t.mwd = g0 ? d0  : (g1 ? d1  : 32'h0);
    t.mwe = g0 ? we0 : (g1 ? we1 : 1'b0);
    t.rd0 = g0 ? rd : 32'h0;
    t.rd1 = g1 ? rd : 32'h0;
    return t;
  endfunction

  task automatic chk(input string vn, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", vn, f, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge CLK);
    Reset = t.rst; Req0 = t.r0; Req1 = t.r1; Lock0 = t.l0; Lock1 = t.l1;
    WE0 = t.we0; WE1 = t.we1; Addr0 = t.a0; WData0 = t.d0;
    Addr1 = t.a1; WData1 = t.d1; MemRD = t.rd;
    #1;
    chk(t.name, "gnt0",   32'(Gnt0),  32'(t.g0));
    chk(t.name, "gnt1",   32'(Gnt1),  32'(t.g1));
    chk(t.name, "mem_a",  MemA,       t.ma);
    chk(t.name, "mem_wd", MemWD,      t.mwd);
    chk(t.name, "mem_we", 32'(MemWE), 32'(t.mwe));
    chk(t.name, "rdata0", RData0,     t.rd0);
    chk(t.name, "rdata1", RData1,     t.rd1);
    @(posedge CLK);
    #1;
    chk(t.name, "owner",     32'(Owner),         32'(t.own));
    chk(t.name, "burst_cnt", 32'(dut.burst_cnt), 32'(t.cnt));
    n_vec++;
  endtask

  vec_t tbl[$];

  initial begin
    Reset = 1'b1; Req0 = 0; Req1 = 0; Lock0 = 0; Lock1 = 0; WE0 = 0; WE1 = 0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0; MemRD = '0;

    // name, rst r0 r1 l0 l1 we0 we1, a0 d0 a1 d1 rd, g0 g1 own cnt
    tbl.push_back(v("reset",   1,1,1,0,0,1,0, 32'h10, 32'h11, 32'h20, 32'h21, 32'hA5, 0,0, 2'b00, 3'd0));
    tbl.push_back(v("tie_1",   0,1,1,0,0,0,0, 32'h10, 32'h11, 32'h20, 32'h21, 32'hA5, 1,0, 2'b00, 3'd0));
    tbl.push_back(v("tie_2",   0,1,1,0,0,0,0, 32'h14, 32'h15, 32'h24, 32'h25, 32'hA6, 0,1, 2'b00, 3'd0));
    tbl.push_back(v("tie_3",   0,1,1,0,0,1,0, 32'h18, 32'h19, 32'h28, 32'h29, 32'hA7, 1,0, 2'b00, 3'd0));
    tbl.push_back(v("tie_4",   0,1,1,0,0,0,1, 32'h1C, 32'h1D, 32'h2C, 32'h2D, 32'hA8, 0,1, 2'b00, 3'd0));
    tbl.push_back(v("idle",    0,0,0,0,0,1,1, 32'h30, 32'h31, 32'h32, 32'h33, 32'h77, 0,0, 2'b00, 3'd0));
    tbl.push_back(v("load0",   0,1,0,0,0,0,0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1,0, 2'b00, 3'd0));
    tbl.push_back(v("store1",  0,0,1,0,0,0,1, 32'h0, 32'h0, 32'h40, 32'h12345678, 32'h0, 0,1, 2'b00, 3'd0));
    tbl.push_back(v("post_st", 0,0,0,0,0,0,1, 32'h0, 32'h0, 32'h40, 32'h12345678, 32'h0, 0,0, 2'b00, 3'd0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Burst limit: port 1 locks, port 0 joins one cycle later and gets in after MB grants.
    apply(v("burst_0", 0,0,1,0,1,0,0, 32'h200, 32'h1, 32'h300, 32'h2, 32'h55, 0,1, 2'b10, 3'd1));
    for (int k = 1; k < MB; k++)
      apply(v($sformatf("burst_%0d", k), 0,1,1,0,1,0,1, 32'h200, 32'h1, 32'h300 + k, 32'h2, 32'h55 + k,
              0,1, 2'b10, 3'(k + 1)));
    apply(v("burst_cut",  0,1,1,0,1,0,1, 32'h200, 32'h1, 32'h310, 32'h2, 32'h66, 1,0, 2'b00, 3'd0));
    apply(v("burst_rest", 0,1,1,0,1,0,0, 32'h200, 32'h1, 32'h320, 32'h2, 32'h67, 0,1, 2'b10, 3'd1));
    apply(v("burst_idle", 0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0, 2'b00, 3'd0));

    // Lock dropped early: port 0 holds two locked grants, then withdraws its request.
    apply(v("drop_0", 0,1,1,1,0,0,0, 32'h400, 32'hA, 32'h500, 32'hB, 32'h81, 1,0, 2'b01, 3'd1));
    apply(v("drop_1", 0,1,1,1,0,1,0, 32'h404, 32'hC, 32'h500, 32'hB, 32'h82, 1,0, 2'b01, 3'd2));
    apply(v("drop_2", 0,0,1,1,0,0,0, 32'h404, 32'hC, 32'h500, 32'hB, 32'h83, 0,1, 2'b00, 3'd0));

    // Reset during a granted store: no grant or write that cycle, and the next tie goes back to port 0.
    apply(v("rst_pre",  0,1,0,1,0,0,0, 32'h600, 32'h0, 32'h0, 32'h0, 32'h90, 1,0, 2'b01, 3'd1));
    apply(v("rst_st",   1,1,0,1,0,1,0, 32'h680, 32'hCAFE, 32'h0, 32'h0, 32'h91, 0,0, 2'b00, 3'd0));
    apply(v("rst_tie",  0,1,1,0,0,0,0, 32'h684, 32'h1, 32'h700, 32'h2, 32'h92, 1,0, 2'b00, 3'd0));
    apply(v("rst_tie2", 0,1,1,0,0,0,0, 32'h684, 32'h1, 32'h700, 32'h2, 32'h93, 0,1, 2'b00, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
